// File: rtl/vcu_sched_pkg.sv
// Shared definitions for the VCU frame scheduler and the task blocks it drives.
// Holds the FSM state encoding, err_status bit positions and the default frame timing.
package vcu_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PWM,
    RUN_PWM,
    WAIT_DPRAM,
    RUN_DPRAM,
    WAIT_TXCP,
    RUN_TXCP
  } sched_state_t;

  // Bit positions shared by err_status, the start vector and the done latches
  localparam int ERR_PWM   = 0;
  localparam int ERR_UNIT  = 1;
  localparam int ERR_DPRAM = 2;
  localparam int ERR_TXCP  = 3;

  // Default frame timing in clk_20M cycles
  localparam int DEF_SYN_PERIOD = 3124;
  localparam int DEF_T_PWM      = 290;
  localparam int DEF_T_DPRAM    = 1200;
  localparam int DEF_T_TXCP     = 1270;
  localparam int DEF_PULSE      = 10;
  localparam int DEF_TIMEOUT    = 600;
  localparam int DEF_FLY_MARGIN = 16;

endpackage

// File: rtl/sched_frame_timer.sv
// Frame timer: ft, flywheel internal sync, sync_lost flag and frame counter.
// The flywheel stays disarmed until the first real frame_sync after reset.
module sched_frame_timer
  import vcu_sched_pkg::*;
#(
  parameter int SYN_PERIOD = DEF_SYN_PERIOD,
  parameter int FLY_MARGIN = DEF_FLY_MARGIN
) (
  input  logic        clk_20M,
  input  logic        reset_n,
  input  logic        frame_sync,
  output logic        sync_eff,
  output logic [15:0] ft,
  output logic        sync_lost,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] FT_FLY = 16'(SYN_PERIOD + FLY_MARGIN);

  logic armed;
  logic sync_int;

  assign sync_int = armed && !frame_sync && (ft == FT_FLY);
  assign sync_eff = frame_sync || sync_int;

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      armed     <= 1'b0;
      ft        <= '0;
      sync_lost <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (frame_sync) armed <= 1'b1;

      // ft free-runs once armed so the flywheel can detect a missing sync
      if (sync_eff)                       ft <= '0;
      else if (armed && ft != 16'hFFFF)   ft <= ft + 16'd1;

      if (frame_sync)    sync_lost <= 1'b0;
      else if (sync_int) sync_lost <= 1'b1;

      if (sync_eff) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/frame_task_scheduler.sv
// Per-frame task scheduler: launches PWM/unit, DPRAM and txCP tasks at fixed
// frame offsets, tracks their done handshakes with timeouts and flags overruns.
module frame_task_scheduler
  import vcu_sched_pkg::*;
#(
  parameter int SYN_PERIOD = DEF_SYN_PERIOD,
  parameter int T_PWM      = DEF_T_PWM,
  parameter int T_DPRAM    = DEF_T_DPRAM,
  parameter int T_TXCP     = DEF_T_TXCP,
  parameter int PULSE      = DEF_PULSE,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int FLY_MARGIN = DEF_FLY_MARGIN
) (
  input  logic        clk_20M,
  input  logic        reset_n,
  input  logic        frame_sync,
  input  logic        done_pwm,
  input  logic        done_unit,
  input  logic        done_dpram,
  input  logic        done_txcp,
  input  logic        clr_err,
  output logic        start_pwm,
  output logic        start_unit,
  output logic        start_dpram,
  output logic        start_txcp,
  output logic        busy,
  output logic        sync_lost,
  output logic        overrun,
  output logic [3:0]  err_status,
  output logic [15:0] frame_cnt
);

  if (T_PWM < 1 || T_PWM + PULSE + TIMEOUT > T_DPRAM ||
      T_TXCP + PULSE + TIMEOUT >= SYN_PERIOD) begin : g_param_chk
    $error("frame_task_scheduler: inconsistent timing parameters");
  end

  localparam int                PCNT_W    = $clog2(PULSE + 1);
  localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE - 1);
  localparam logic [15:0]       FT_PWM    = 16'(T_PWM - 1);
  localparam logic [15:0]       FT_DPRAM  = 16'(T_DPRAM - 1);
  localparam logic [15:0]       FT_TXCP   = 16'(T_TXCP - 1);
  localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT - 1);

  sched_state_t      state_q, state_nx;
  logic [3:0]        start_q, start_nx;
  logic [PCNT_W-1:0] pcnt_q, pcnt_nx;
  logic [15:0]       tcnt_q, tcnt_nx;
  logic [3:0]        dlat_q, dlat_nx;
  logic [3:0]        err_q, err_nx;
  logic              ovr_q, ovr_nx;
  logic              busy_q;

  logic              sync_eff;
  logic [15:0]       ft;
  logic [3:0]        done_v;
  logic [3:0]        hit;
  logic              tmo;
  logic              pulse_fin;
  logic              run_st;

  sched_frame_timer #(
    .SYN_PERIOD (SYN_PERIOD),
    .FLY_MARGIN (FLY_MARGIN)
  ) u_timer (
    .clk_20M    (clk_20M),
    .reset_n    (reset_n),
    .frame_sync (frame_sync),
    .sync_eff   (sync_eff),
    .ft         (ft),
    .sync_lost  (sync_lost),
    .frame_cnt  (frame_cnt)
  );

  assign done_v    = {done_txcp, done_dpram, done_unit, done_pwm};
  assign hit       = dlat_q | done_v;
  // tcnt is 0 in the first start-high cycle, so TIMEOUT is reached at this edge
  assign tmo       = (tcnt_q == TMO_LAST);
  assign pulse_fin = (start_q == '0) || (pcnt_q == '0);
  assign run_st    = (state_q == RUN_PWM) || (state_q == RUN_DPRAM) || (state_q == RUN_TXCP);

  always_comb begin
    state_nx = state_q;
    start_nx = start_q;
    pcnt_nx  = pcnt_q;
    tcnt_nx  = tcnt_q;
    dlat_nx  = dlat_q;
    err_nx   = clr_err ? '0 : err_q;
    ovr_nx   = clr_err ? 1'b0 : ovr_q;

    // Start pulses run their full width independently of the done handshake
    if (start_q != '0) begin
      if (pcnt_q == '0) start_nx = '0;
      else              pcnt_nx  = pcnt_q - PCNT_W'(1);
    end

    if (run_st && tcnt_q != 16'hFFFF) tcnt_nx = tcnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (sync_eff) state_nx = WAIT_PWM;
      end
      WAIT_PWM: begin
        if (ft >= FT_PWM) begin
          state_nx           = RUN_PWM;
          start_nx           = '0;
          start_nx[ERR_PWM]  = 1'b1;
          start_nx[ERR_UNIT] = 1'b1;
          pcnt_nx            = PCNT_LOAD;
          tcnt_nx            = '0;
          dlat_nx            = '0;
        end
      end
      RUN_PWM: begin
        dlat_nx[ERR_PWM]  = hit[ERR_PWM];
        dlat_nx[ERR_UNIT] = hit[ERR_UNIT];
        if (tmo && !hit[ERR_PWM])  err_nx[ERR_PWM]  = 1'b1;
        if (tmo && !hit[ERR_UNIT]) err_nx[ERR_UNIT] = 1'b1;
        if ((hit[ERR_PWM] && hit[ERR_UNIT] && pulse_fin) || tmo) begin
          state_nx = WAIT_DPRAM;
          dlat_nx  = '0;
        end
      end
      WAIT_DPRAM: begin
        if (ft >= FT_DPRAM) begin
          state_nx            = RUN_DPRAM;
          start_nx            = '0;
          start_nx[ERR_DPRAM] = 1'b1;
          pcnt_nx             = PCNT_LOAD;
          tcnt_nx             = '0;
          dlat_nx             = '0;
        end
      end
      RUN_DPRAM: begin
        dlat_nx[ERR_DPRAM] = hit[ERR_DPRAM];
        if (tmo && !hit[ERR_DPRAM]) err_nx[ERR_DPRAM] = 1'b1;
        if ((hit[ERR_DPRAM] && pulse_fin) || tmo) begin
          state_nx = WAIT_TXCP;
          dlat_nx  = '0;
        end
      end
      WAIT_TXCP: begin
        if (ft >= FT_TXCP) begin
          state_nx           = RUN_TXCP;
          start_nx           = '0;
          start_nx[ERR_TXCP] = 1'b1;
          pcnt_nx            = PCNT_LOAD;
          tcnt_nx            = '0;
          dlat_nx            = '0;
        end
      end
      RUN_TXCP: begin
        dlat_nx[ERR_TXCP] = hit[ERR_TXCP];
        if (tmo && !hit[ERR_TXCP]) err_nx[ERR_TXCP] = 1'b1;
        if ((hit[ERR_TXCP] && pulse_fin) || tmo) begin
          state_nx = IDLE;
          dlat_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A sync while the frame is still in progress abandons it and restarts
    if (sync_eff && state_q != IDLE) begin
      state_nx = WAIT_PWM;
      ovr_nx   = 1'b1;
      start_nx = '0;
      pcnt_nx  = '0;
      tcnt_nx  = '0;
      dlat_nx  = '0;
    end
  end

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= '0;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      dlat_q  <= '0;
      err_q   <= '0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      start_q <= start_nx;
      pcnt_q  <= pcnt_nx;
      tcnt_q  <= tcnt_nx;
      dlat_q  <= dlat_nx;
      err_q   <= err_nx;
      ovr_q   <= ovr_nx;
      busy_q  <= (state_nx != IDLE);
    end
  end

  assign start_pwm   = start_q[ERR_PWM];
  assign start_unit  = start_q[ERR_UNIT];
  assign start_dpram = start_q[ERR_DPRAM];
  assign start_txcp  = start_q[ERR_TXCP];
  assign busy        = busy_q;
  assign overrun     = ovr_q;
  assign err_status  = err_q;

endmodule
